quiz_ctrl: RTL and testbench
============================

QUIZ_CTRL -- requirements
Module: quiz_ctrl

Interface
REQ-001 SHALL have parameter ANSWER_CYC, default 32'd100000000, answer window in m_clock cycles.
REQ-002 SHALL have parameter OPEN_CYC, default 32'd500000000, buzz-in window in m_clock cycles.
REQ-003 m_clock  in  1  sole clock; all logic on rising edge.
REQ-004 p_reset  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  host pulse, begins a round.
REQ-006 JUDGE_OK  in  1  host pulse, current answer correct.
REQ-007 JUDGE_NG  in  1  host pulse, current answer wrong.
REQ-008 SCORE_CLR  in  1  clears all scores.
REQ-009 RANK_IN  in  25  five 5-bit rank fields, player i = bits[5i+4:5i]; 0 = no press, nonzero smaller = earlier.
REQ-010 RANK_CLR  out  1  one-cycle clear pulse to the button-ranking block.
REQ-011 STATE  out  2  FSM state: IDLE=0, CLEAR=1, OPEN=2, ANSWER=3.
REQ-012 ANSWERER  out  5  one-hot current answering player, 0 when none.
REQ-013 LOCK  out  5  players locked out this round.
REQ-014 SCORE  out  20  five 4-bit scores, player i = bits[4i+3:4i].
REQ-015 ROUND_DONE  out  1  one-cycle pulse when a round ends.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 IDLE: START -> CLEAR next cycle; START in any other state SHALL be ignored.
REQ-018 CLEAR: RANK_CLR=1 for exactly this one cycle, LOCK<=0, window timer<=OPEN_CYC-1; -> OPEN.
REQ-019 OPEN: candidate = unlocked player with nonzero field of minimum value; equal values -> lowest index.
REQ-020 OPEN with candidate at cycle t: at t+1 STATE=ANSWER, ANSWERER=one-hot candidate, timer=ANSWER_CYC-1.
REQ-021 OPEN with LOCK=5'b11111, or window timer reaching 0 with no candidate: -> IDLE, ROUND_DONE=1 for one cycle.
REQ-022 OPEN window timer SHALL not reload on return from ANSWER; it continues from its prior value.
REQ-023 ANSWER: JUDGE_OK -> SCORE of answerer +1, saturating at 15; ROUND_DONE pulse; ANSWERER<=0; -> IDLE.
REQ-024 ANSWER: JUDGE_NG or answer timer reaching 0 -> LOCK |= ANSWERER, ANSWERER<=0, score unchanged, -> OPEN; RANK_CLR SHALL not be pulsed.
REQ-025 JUDGE_OK and JUDGE_NG in the same cycle SHALL be treated as JUDGE_NG.
REQ-026 JUDGE_* outside ANSWER SHALL be ignored.
REQ-027 SCORE_CLR SHALL zero all scores next cycle in any state and take priority over a same-cycle increment.
REQ-028 Timers SHALL be 32-bit down-counters that hold at 0.

Reset
REQ-029 p_reset=1 at a rising edge SHALL set STATE=IDLE, ANSWERER=0, LOCK=0, SCORE=0, RANK_CLR=0, ROUND_DONE=0, timers=0.
REQ-030 Reset SHALL override every other input, including mid-round and mid-answer.

Structure
REQ-031 Package quiz_pkg SHALL hold the state encoding, NPLAYER=5, RANK_W=5 and SCORE_W=4.
REQ-032 Combinational sub-module quiz_pick_first SHALL implement the REQ-019 selector: inputs RANK_IN and LOCK; outputs a valid bit and a one-hot pick.

Verification
REQ-033 Reset, START, RANK_IN player2=1, then JUDGE_OK -> RANK_CLR pulse in CLEAR, ANSWERER=5'b00100, SCORE[11:8]=1, ROUND_DONE pulse, STATE=0.
REQ-034 RANK_IN p0=3, p1=1, p4=2; NG, NG, OK -> ANSWERER sequence 00010, 10000, 00001; LOCK=00010 then 10010; SCORE[3:0]=1.
REQ-035 ANSWER_CYC=4, no judge -> answerer locked 4 cycles after ANSWER entry, STATE=OPEN; with no other press and OPEN_CYC=8 -> IDLE plus ROUND_DONE.
REQ-036 Score 15 plus JUDGE_OK -> stays 15; SCORE_CLR with same-cycle JUDGE_OK -> 0.
REQ-037 Equal fields p1=p3=2 -> player1 picked; JUDGE_OK and JUDGE_NG together -> player1 locked, no score change.
REQ-038 p_reset in ANSWER -> all REQ-029 values next cycle; later START runs a normal round.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared constants for the quiz controller: player count, field widths, FSM encoding.
package quiz_pkg;

  localparam int NPLAYER = 5;
  localparam int RANK_W  = 5;
  localparam int SCORE_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;
  localparam logic [1:0] ST_ANSWER = 2'd3;

endpackage

// File: rtl/quiz_pick_first.sv
// Chooses the earliest unlocked buzzer: smallest nonzero rank wins, lowest index breaks ties.
module quiz_pick_first
  import quiz_pkg::*;
(
  input  logic [NPLAYER*RANK_W-1:0] rank_in,
  input  logic [NPLAYER-1:0]        lock,
  output logic                      valid,
  output logic [NPLAYER-1:0]        pick
);

  logic [RANK_W-1:0] best;
  logic [RANK_W-1:0] field;

  // Linear scan; strict less-than keeps the lower index on equal ranks.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    best  = '0;
    field = '0;
    for (int i = 0; i < NPLAYER; i++) begin
      field = rank_in[i*RANK_W +: RANK_W];
      if (field != '0 && !lock[i] && (!valid || field < best)) begin
        valid   = 1'b1;
        best    = field;
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quiz_ctrl.sv
// Quiz round controller: opens a buzz-in window, hands the floor to the earliest
// buzzer, applies host judgements, tracks lockouts and saturating scores.
module quiz_ctrl
  import quiz_pkg::*;
#(
  parameter logic [31:0] ANSWER_CYC = 32'd100000000,
  parameter logic [31:0] OPEN_CYC   = 32'd500000000
) (
  input  logic                        m_clock,
  input  logic                        p_reset,
  input  logic                        START,
  input  logic                        JUDGE_OK,
  input  logic                        JUDGE_NG,
  input  logic                        SCORE_CLR,
  input  logic [NPLAYER*RANK_W-1:0]   RANK_IN,
  output logic                        RANK_CLR,
  output logic [1:0]                  STATE,
  output logic [NPLAYER-1:0]          ANSWERER,
  output logic [NPLAYER-1:0]          LOCK,
  output logic [NPLAYER*SCORE_W-1:0]  SCORE,
  output logic                        ROUND_DONE
);

  logic               cand_vld;
  logic [NPLAYER-1:0] cand_pick;
  logic [31:0]        open_tmr;
  logic [31:0]        ans_tmr;
  logic               judge_ok;

  // A simultaneous OK and NG counts as NG.
  assign judge_ok = JUDGE_OK & ~JUDGE_NG;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  quiz_pick_first u_pick (
    .rank_in (RANK_IN),
    .lock    (LOCK),
    .valid   (cand_vld),
    .pick    (cand_pick)
  );

  // Round sequencing, lockouts and the two window timers.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      STATE      <= ST_IDLE;
      ANSWERER   <= '0;
      LOCK       <= '0;
      RANK_CLR   <= 1'b0;
      ROUND_DONE <= 1'b0;
      open_tmr   <= '0;
      ans_tmr    <= '0;
    end else begin
      RANK_CLR   <= 1'b0;
      ROUND_DONE <= 1'b0;
      case (STATE)
        ST_IDLE: begin
          if (START) begin
            STATE    <= ST_CLEAR;
            RANK_CLR <= 1'b1;
          end
        end
        ST_CLEAR: begin
          LOCK     <= '0;
          open_tmr <= OPEN_CYC - 32'd1;
          STATE    <= ST_OPEN;
        end
        ST_OPEN: begin
          // The window keeps running across answers; it is only reloaded in CLEAR.
          if (open_tmr != '0) open_tmr <= open_tmr - 32'd1;
          if (cand_vld) begin
            STATE    <= ST_ANSWER;
            ANSWERER <= cand_pick;
            ans_tmr  <= ANSWER_CYC - 32'd1;
          end else if (LOCK == '1 || open_tmr == '0) begin
            STATE      <= ST_IDLE;
            ROUND_DONE <= 1'b1;
          end
        end
        default: begin
          if (JUDGE_NG) begin
            LOCK     <= LOCK | ANSWERER;
            ANSWERER <= '0;
            STATE    <= ST_OPEN;
          end else if (judge_ok) begin
            ANSWERER   <= '0;
            ROUND_DONE <= 1'b1;
            STATE      <= ST_IDLE;
          end else if (ans_tmr == '0) begin
            LOCK     <= LOCK | ANSWERER;
            ANSWERER <= '0;
            STATE    <= ST_OPEN;
          end else begin
            ans_tmr <= ans_tmr - 32'd1;
          end
        end
      endcase
    end
  end

  // Scores: clear wins over a same-cycle correct answer.
  always_ff @(posedge m_clock) begin
    if (p_reset || SCORE_CLR) begin
      SCORE <= '0;
    end else if (STATE == ST_ANSWER && judge_ok) begin
      for (int i = 0; i < NPLAYER; i++) begin
        if (ANSWERER[i]) SCORE[i*SCORE_W +: SCORE_W] <= sat_inc(SCORE[i*SCORE_W +: SCORE_W]);
      end
    end
  end

endmodule

// File: tb/tb_quiz_ctrl.sv
// Directed bench for quiz_ctrl with a behavioural round model checked every cycle.
module tb_quiz_ctrl;

  localparam logic [31:0] A_CYC = 32'd4;
  localparam logic [31:0] O_CYC = 32'd8;

  logic        clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        start = 1'b0, judge_ok = 1'b0, judge_ng = 1'b0, score_clr = 1'b0;
  logic [24:0] rank_in = '0;
  logic        rank_clr, round_done;
  logic [1:0]  state;
  logic [4:0]  answerer, lock;
  logic [19:0] score;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  quiz_ctrl #(.ANSWER_CYC(A_CYC), .OPEN_CYC(O_CYC)) dut (
    .m_clock(clk), .p_reset(p_reset), .START(start), .JUDGE_OK(judge_ok),
    .JUDGE_NG(judge_ng), .SCORE_CLR(score_clr), .RANK_IN(rank_in),
    .RANK_CLR(rank_clr), .STATE(state), .ANSWERER(answerer), .LOCK(lock),
    .SCORE(score), .ROUND_DONE(round_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 clearing, 2 buzz-in window, 3 someone answering
  logic [1:0] m_phase = 2'd0;
  int         m_who = -1;          // answering player index, -1 = nobody
  bit [4:0]   m_locked = '0;
  int         m_pts[5] = '{0, 0, 0, 0, 0};
  bit         m_rclr = 1'b0, m_done = 1'b0;
  int         open_used = 0;       // buzz-in cycles already spent this round
  int         ans_used = 0;        // cycles the current answerer has used

  function automatic int earliest(input logic [24:0] r, input bit [4:0] lk);
    int who = -1;
    int best = 0;
    for (int p = 0; p < 5; p++) begin
      int f = int'((r >> (5 * p)) & 25'h1f);
      if (f != 0 && !lk[p] && (who < 0 || f < best)) begin
        who = p;
        best = f;
      end
    end
    return who;
  endfunction

  always @(posedge clk) begin
    int scorer;
    int c;
    scorer = -1;
    if (p_reset) begin
      m_phase = 0; m_who = -1; m_locked = '0; m_rclr = 0; m_done = 0;
      open_used = 0; ans_used = 0;
      for (int p = 0; p < 5; p++) m_pts[p] = 0;
    end else begin
      m_rclr = 0;
      m_done = 0;
      case (m_phase)
        2'd0: if (start) begin m_phase = 1; m_rclr = 1; end
        2'd1: begin m_locked = '0; open_used = 0; m_phase = 2; end
        2'd2: begin
          c = earliest(rank_in, m_locked);
          if (c >= 0) begin
            m_who = c; ans_used = 0; m_phase = 3;
          end else if (m_locked == 5'h1f || open_used >= int'(O_CYC) - 1) begin
            m_phase = 0; m_done = 1;
          end
          open_used++;
        end
        default: begin
          if (judge_ng || (!judge_ok && ans_used >= int'(A_CYC) - 1)) begin
            m_locked[m_who] = 1'b1; m_who = -1; m_phase = 2;
          end else if (judge_ok) begin
            scorer = m_who; m_who = -1; m_phase = 0; m_done = 1;
          end else begin
            ans_used++;
          end
        end
      endcase
      if (score_clr) begin
        for (int p = 0; p < 5; p++) m_pts[p] = 0;
      end else if (scorer >= 0 && m_pts[scorer] < 15) begin
        m_pts[scorer]++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [35:0] exp_v, act_v;
    logic [19:0] exp_s;
    logic [4:0]  exp_a;
    if (chk_en) begin
      for (int p = 0; p < 5; p++) exp_s[4*p +: 4] = 4'(m_pts[p]);
      exp_a = (m_who < 0) ? 5'd0 : 5'(1 << m_who);
      exp_v = {m_phase, exp_a, m_locked, exp_s, m_rclr, m_done, 2'b00};
      act_v = {state, answerer, lock, score, rank_clr, round_done, 2'b00};
      n_chk++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL model t=%0t got st=%0d ans=%b lock=%b score=%h rclr=%b done=%b required st=%0d ans=%b lock=%b score=%h rclr=%b done=%b",
                 $time, state, answerer, lock, score, rank_clr, round_done,
                 m_phase, exp_a, m_locked, exp_s, m_rclr, m_done);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ok_round();
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    judge_ok = 1; cyc(); judge_ok = 0;
  endtask

  initial begin
    chk_en = 1;
    // Reset state
    cyc(); cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", {answerer, lock, rank_clr, round_done}, 0);
    chk("rst_score", 32'(score), 0);
    p_reset = 0;

    // Single player 2 answers correctly
    rank_in = 25'd1 << 10;
    start = 1; cyc(); start = 0;
    chk("s1_clear_state", 32'(state), 1);
    chk("s1_rank_clr", 32'(rank_clr), 1);
    cyc();
    chk("s1_open_state", 32'(state), 2);
    chk("s1_rank_clr_off", 32'(rank_clr), 0);
    cyc();
    chk("s1_answerer", 32'(answerer), 32'b00100);
    judge_ok = 1; cyc(); judge_ok = 0;
    chk("s1_score_p2", 32'(score[11:8]), 1);
    chk("s1_done", 32'(round_done), 1);
    chk("s1_idle", 32'(state), 0);
    cyc();
    chk("s1_done_pulse", 32'(round_done), 0);

    // NG, NG, OK across three buzzers
    rank_in = 25'd3 | (25'd1 << 5) | (25'd2 << 20);
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("s2_ans1", 32'(answerer), 32'b00010);
    judge_ng = 1; cyc(); judge_ng = 0;
    chk("s2_lock1", 32'(lock), 32'b00010);
    cyc();
    chk("s2_ans2", 32'(answerer), 32'b10000);
    judge_ng = 1; cyc(); judge_ng = 0;
    chk("s2_lock2", 32'(lock), 32'b10010);
    cyc();
    chk("s2_ans3", 32'(answerer), 32'b00001);
    judge_ok = 1; cyc(); judge_ok = 0;
    chk("s2_score_p0", 32'(score[3:0]), 1);

    // Answer timeout, then window expiry
    rank_in = 25'd1 << 15;
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("s3_ans", 32'(answerer), 32'b01000);
    cyc(); cyc(); cyc();
    chk("s3_still_answer", 32'(state), 3);
    cyc();
    chk("s3_timeout_open", 32'(state), 2);
    chk("s3_timeout_lock", 32'(lock), 32'b01000);
    for (int k = 0; k < 6; k++) begin
      start = (k == 0);
      cyc();
    end
    start = 0;
    chk("s3_window_last", 32'(state), 2);
    cyc();
    chk("s3_expire_idle", 32'(state), 0);
    chk("s3_expire_done", 32'(round_done), 1);

    // Saturation and clear priority
    rank_in = 25'd1;
    for (int k = 0; k < 14; k++) ok_round();
    chk("s4_score15", 32'(score[3:0]), 15);
    ok_round();
    chk("s4_sat", 32'(score[3:0]), 15);
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    judge_ok = 1; score_clr = 1; cyc(); judge_ok = 0; score_clr = 0;
    chk("s4_clr_wins", 32'(score), 0);

    // Tie break and OK+NG together
    rank_in = (25'd2 << 5) | (25'd2 << 15);
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("s5_tie", 32'(answerer), 32'b00010);
    judge_ok = 1; judge_ng = 1; cyc(); judge_ok = 0; judge_ng = 0;
    chk("s5_both_lock", 32'(lock), 32'b00010);
    chk("s5_both_score", 32'(score), 0);
    cyc();
    chk("s5_next", 32'(answerer), 32'b01000);
    judge_ok = 1; cyc(); judge_ok = 0;
    chk("s5_score_p3", 32'(score[15:12]), 1);
    judge_ok = 1; cyc(); judge_ok = 0;
    chk("s5_idle_judge", 32'(score[15:12]), 1);

    // Reset mid-answer, then a normal round
    rank_in = (25'd1 << 10) | (25'd3 << 20);
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    judge_ng = 1; cyc(); judge_ng = 0;
    chk("s6_lock", 32'(lock), 32'b00100);
    cyc();
    chk("s6_ans", 32'(answerer), 32'b10000);
    p_reset = 1; judge_ok = 1; cyc(); p_reset = 0; judge_ok = 0;
    chk("s6_rst_state", 32'(state), 0);
    chk("s6_rst_outs", {answerer, lock, rank_clr, round_done}, 0);
    chk("s6_rst_score", 32'(score), 0);
    rank_in = 25'd1;
    start = 1; cyc(); start = 0;
    chk("s6_rank_clr", 32'(rank_clr), 1);
    cyc(); cyc();
    chk("s6_ans2", 32'(answerer), 32'b00001);
    judge_ok = 1; cyc(); judge_ok = 0;
    chk("s6_score", 32'(score), 1);
    chk("s6_done", 32'(round_done), 1);
    cyc(); cyc();
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
